load_store_unit: RTL and testbench
==================================

# load_store_unit

Data-side memory port of the multi-cycle RISC-V core, placed between the core control FSM and the word-wide byte-enabled data RAM. Takes one load or store request at a time from the MEM_ACCESS stage and checks natural alignment. Stores are steered onto byte lanes. Loads are extracted and sign- or zero-extended. Reports completion to the UPDATE/WAIT_UPDATE stage with a single-cycle response pulse.

## Interface
- WORD_SIZE, 32, data and address width; only 32 is supported.
- MEM_LATENCY, 1, cycles from `mem_rd_en` to valid `mem_rdata`; legal range 1..4.

- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  in  1  loads only: zero-extend instead of sign-extend.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_error  out  1  qualified by resp_valid: misaligned or illegal size.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- mem_addr  out  32  word address, `{req_addr[31:2],2'b00}`.
- mem_rd_en  out  1  one-cycle read strobe.
- mem_wr_en  out  1  one-cycle write strobe.
- mem_byte_en  out  4  lane enables; bit k = byte offset k.
- mem_wdata  out  32  lane-steered store data.
- mem_rdata  in  32  RAM read data.

## Operation
- The lane mapping is little-endian: byte offset k uses bits [8k+7:8k].
- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - `req_ready`=1.
  - On `req_valid`, latch addr, size, write, unsigned and wdata.
  - If there is an alignment or size error, go to RESP with the error flag set. Otherwise go to ISSUE.
- Alignment rules:
  - Half requires `addr[0]`=0.
  - Word requires `addr[1:0]`=0.
  - Size 11 is always an error.
  - An error performs no memory access.
- ISSUE:
  - For a store: `mem_wr_en`=1, then go to RESP.
  - For a load: `mem_rd_en`=1, `mem_byte_en`=4'b1111, then go to WAIT.
- Store byte enables and data:
  - Byte: `mem_byte_en`=1<<off, and `wdata[7:0]` is replicated to all lanes.
  - Half: `mem_byte_en`=4'b0011 or 4'b1100, and `wdata[15:0]` is replicated to both halves.
  - Word: `mem_byte_en`=4'b1111.
- WAIT:
  - A down-counter is loaded with MEM_LATENCY-1 on entry to WAIT.
  - When the counter reaches 0, capture `mem_rdata`, extract the addressed lane(s), extend, and go to RESP.
- RESP: `resp_valid`=1 for exactly one cycle, then go to IDLE.
- Outputs are registered. `mem_*` strobes are 0 outside ISSUE. `mem_addr`, `mem_byte_en` and `mem_wdata` hold their value until the next accepted request.
- `req_valid` outside IDLE is ignored; no queueing.
- Reset value of every output is 0, except `req_ready`=1.

## Timing
- Request accepted at edge T (IDLE, `req_valid`=1).
- Store: strobe in cycle T+1; `resp_valid` in cycle T+2.
- Load:
  - `mem_rd_en` in cycle T+1.
  - `mem_rdata` is sampled in cycle T+1+MEM_LATENCY.
  - `resp_valid` and `resp_rdata` appear in cycle T+2+MEM_LATENCY.
- Error: `resp_valid`=1, `resp_error`=1 in cycle T+1; no strobe at any time.
- Next request can be accepted in the cycle after `resp_valid`, since the unit is back in IDLE.
- Reset asserted in any state:
  - Next cycle is IDLE with all strobes and `resp_valid` at 0.
  - An in-flight read is discarded, and no response is ever issued for it.
- Reset has priority over a simultaneous `req_valid`.

## Structure
- Shared package `lsu_pkg`:
  - Size encodings SIZE_BYTE/SIZE_HALF/SIZE_WORD/SIZE_ILLEGAL.
  - The FSM state enum.
  - MAX_MEM_LATENCY=4.
- One sub-module, `load_extend`: purely combinational. It maps (`mem_rdata`, offset, size, unsigned) to the extended 32-bit result, so it can be unit-tested alone.
- The counter width is $clog2(MAX_MEM_LATENCY).

## Test plan
- Word store, then load, at 0x100 with 0xDEADBEEF:
  - Store: `mem_byte_en`=1111, `mem_wdata`=0xDEADBEEF, `resp_valid` at T+2.
  - Load: `resp_rdata`=0xDEADBEEF at T+3 (MEM_LATENCY=1).
- Byte store at 0x103, `wdata`=0x123456AB: `mem_addr`=0x100, `mem_byte_en`=1000, `mem_wdata`=0xABABABAB.
- Byte load at 0x102, RAM word 0x00800000:
  - Signed: `resp_rdata`=0xFFFFFF80.
  - Unsigned: `resp_rdata`=0x00000080.
  - Half load at 0x102 of RAM word 0x80010000, signed: `resp_rdata`=0xFFFF8001.
- Errors:
  - Half load at 0x101: `resp_error`=1 at T+1, no `mem_rd_en`.
  - Word store at 0x102: error, no `mem_wr_en`.
  - `size`=11 at 0x100: error.
- MEM_LATENCY=3 word load: `mem_rd_en` at T+1, `resp_valid` exactly at T+5, `req_ready`=0 from T+1 through T+5.
- Reset during WAIT:
  - `resp_valid` never pulses for that load.
  - `req_ready`=1 the cycle after reset.
  - An immediate new load completes correctly.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types for the data-side load/store unit: size codes,
// FSM state encoding, latency limit and the alignment check.
package lsu_pkg;

  localparam logic [1:0] SIZE_BYTE    = 2'b00;
  localparam logic [1:0] SIZE_HALF    = 2'b01;
  localparam logic [1:0] SIZE_WORD    = 2'b10;
  localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

  localparam int MAX_MEM_LATENCY = 4;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } lsu_state_e;

  // 1 when size is illegal or the offset breaks natural alignment.
  function automatic logic acc_error(
    input logic [1:0] size,
    input logic [1:0] off
  );
    logic e;
    case (size)
      SIZE_BYTE: e = 1'b0;
      SIZE_HALF: e = off[0];
      SIZE_WORD: e = (off != 2'b00);
      default:   e = 1'b1;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Load lane extraction: picks the addressed byte/half of a RAM word
// and sign- or zero-extends it. Ports: rdata_i, off_i, size_i, unsigned_i -> data_o.
module load_extend
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [31:0] data_o
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    b = rdata_i[7:0];
    case (off_i)
      2'd1:    b = rdata_i[15:8];
      2'd2:    b = rdata_i[23:16];
      2'd3:    b = rdata_i[31:24];
      default: ;
    endcase
    h = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    data_o = '0;
    case (size_i)
      SIZE_BYTE: data_o = {{24{~unsigned_i & b[7]}}, b};
      SIZE_HALF: data_o = {{16{~unsigned_i & h[15]}}, h};
      SIZE_WORD: data_o = rdata_i;
      default:   ;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Data-side memory port: one aligned load/store at a time, lane steering,
// load extension, one-cycle response. Ports: req_* in, resp_* out, mem_* RAM side.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int WORD_SIZE   = 32,
  parameter int MEM_LATENCY = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [WORD_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  output logic                 resp_valid,
  output logic                 resp_error,
  output logic [WORD_SIZE-1:0] resp_rdata,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic                 mem_rd_en,
  output logic                 mem_wr_en,
  output logic [3:0]           mem_byte_en,
  output logic [WORD_SIZE-1:0] mem_wdata,
  input  logic [WORD_SIZE-1:0] mem_rdata
);

  localparam int CW = $clog2(MAX_MEM_LATENCY);
  localparam logic [CW-1:0] CNT_INIT = CW'(MEM_LATENCY - 1);

  lsu_state_e           state_q;
  logic                 ready_q;
  logic                 rvalid_q;
  logic                 rerr_q;
  logic [WORD_SIZE-1:0] rdata_q;
  logic [WORD_SIZE-1:0] addr_q;
  logic                 rd_q;
  logic                 wr_q;
  logic [3:0]           be_q;
  logic [WORD_SIZE-1:0] wd_q;
  logic [CW-1:0]        cnt_q;
  logic [1:0]           size_q;
  logic [1:0]           off_q;
  logic                 write_q;
  logic                 uns_q;

  logic                 req_err;
  logic [3:0]           st_be;
  logic [WORD_SIZE-1:0] st_wd;
  logic [WORD_SIZE-1:0] ext;

  assign req_err = acc_error(req_size, req_addr[1:0]);

  // Store lane steering: narrow data is replicated so the
  // byte enables alone select the destination lane(s).
  always_comb begin
    st_be = 4'b1111;
    st_wd = req_wdata;
    case (req_size)
      SIZE_BYTE: begin
        st_be = 4'b0001 << req_addr[1:0];
        st_wd = {4{req_wdata[7:0]}};
      end
      SIZE_HALF: begin
        st_be = req_addr[1] ? 4'b1100 : 4'b0011;
        st_wd = {2{req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  load_extend u_ext (
    .rdata_i    (mem_rdata),
    .off_i      (off_q),
    .size_i     (size_q),
    .unsigned_i (uns_q),
    .data_o     (ext)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ready_q  <= 1'b1;
      rvalid_q <= 1'b0;
      rerr_q   <= 1'b0;
      rdata_q  <= '0;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      be_q     <= '0;
      wd_q     <= '0;
      cnt_q    <= '0;
      size_q   <= SIZE_BYTE;
      off_q    <= '0;
      write_q  <= 1'b0;
      uns_q    <= 1'b0;
    end else begin
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      rvalid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            ready_q <= 1'b0;
            size_q  <= req_size;
            off_q   <= req_addr[1:0];
            write_q <= req_write;
            uns_q   <= req_unsigned;
            addr_q  <= {req_addr[WORD_SIZE-1:2], 2'b00};
            if (req_err) begin
              state_q  <= RESP;
              rvalid_q <= 1'b1;
              rerr_q   <= 1'b1;
              rdata_q  <= '0;
            end else begin
              state_q <= ISSUE;
              be_q    <= req_write ? st_be : 4'b1111;
              wd_q    <= st_wd;
              wr_q    <= req_write;
              rd_q    <= ~req_write;
            end
          end
        end
        ISSUE: begin
          if (write_q) begin
            state_q  <= RESP;
            rvalid_q <= 1'b1;
            rerr_q   <= 1'b0;
            rdata_q  <= '0;
          end else begin
            state_q <= WAIT;
            cnt_q   <= CNT_INIT;
          end
        end
        WAIT: begin
          if (cnt_q == '0) begin
            state_q  <= RESP;
            rvalid_q <= 1'b1;
            rerr_q   <= 1'b0;
            rdata_q  <= ext;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        RESP: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
        default: begin
          state_q <= IDLE;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready   = ready_q;
  assign resp_valid  = rvalid_q;
  assign resp_error  = rerr_q;
  assign resp_rdata  = rdata_q;
  assign mem_addr    = addr_q;
  assign mem_rd_en   = rd_q;
  assign mem_wr_en   = wr_q;
  assign mem_byte_en = be_q;
  assign mem_wdata   = wd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (latency 1 and 3) each with a
// byte-enabled RAM model; table vectors, scoreboard, reset-in-WAIT sequence.
module tb_load_store_unit;

  typedef struct {
    logic        wr;
    logic [1:0]  sz;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    logic [3:0]  be;
    logic [31:0] wd;
  } rec_t;

  typedef struct {
    int          g;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  logic clk;
  logic rst;
  logic [1:0]       req_valid, req_ready, req_write, req_unsigned;
  logic [1:0]       resp_valid, resp_error, mem_rd_en, mem_wr_en;
  logic [1:0][1:0]  req_size;
  logic [1:0][31:0] req_addr, req_wdata, resp_rdata;
  logic [1:0][31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0][3:0]  mem_byte_en;

  int asserts = 0;
  int fails   = 0;
  exp_t sb[$];
  rec_t t0[$];
  rec_t t1[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int L = (g == 0) ? 1 : 3;
    logic [31:0] mem [256];
    logic [31:0] pd [L];
    logic        pv [L];

    load_store_unit #(.MEM_LATENCY(L)) u_dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid[g]),
      .req_ready    (req_ready[g]),
      .req_write    (req_write[g]),
      .req_size     (req_size[g]),
      .req_unsigned (req_unsigned[g]),
      .req_addr     (req_addr[g]),
      .req_wdata    (req_wdata[g]),
      .resp_valid   (resp_valid[g]),
      .resp_error   (resp_error[g]),
      .resp_rdata   (resp_rdata[g]),
      .mem_addr     (mem_addr[g]),
      .mem_rd_en    (mem_rd_en[g]),
      .mem_wr_en    (mem_wr_en[g]),
      .mem_byte_en  (mem_byte_en[g]),
      .mem_wdata    (mem_wdata[g]),
      .mem_rdata    (mem_rdata[g])
    );

    // RAM: read data is valid only in the single cycle L cycles after
    // the strobe; any other cycle shows a poison pattern.
    always @(posedge clk) begin
      if (mem_wr_en[g])
        for (int k = 0; k < 4; k++)
          if (mem_byte_en[g][k])
            mem[mem_addr[g][9:2]][8*k +: 8] <= mem_wdata[g][8*k +: 8];
      pv[0] <= mem_rd_en[g];
      pd[0] <= mem[mem_addr[g][9:2]];
      for (int k = 1; k < L; k++) begin
        pv[k] <= pv[k-1];
        pd[k] <= pd[k-1];
      end
    end
    assign mem_rdata[g] = pv[L-1] ? pd[L-1] : 32'hA5A5A5A5;
  end

  function automatic int lat(input int g);
    return (g == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Scoreboard side: every response pulse is matched to the oldest request.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (resp_valid[i]) begin
        if (sb.size() == 0) begin
          asserts++;
          fails++;
          $display("FAIL unexpected_resp: inst %0d got a response, none expected", i);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("resp_inst", 32'(i), 32'(e.g));
          chk("resp_error", 32'(resp_error[i]), 32'(e.err));
          chk("resp_rdata", resp_rdata[i], e.rdata);
        end
      end
    end
  end

  task automatic run(input int g, input rec_t r);
    int resp_n, wr_n, rd_n, strobes, exp_n;
    logic rdy_busy, rdy_after;
    @(negedge clk);
    chk("ready_idle", 32'(req_ready[g]), 32'd1);
    req_write[g]    = r.wr;
    req_size[g]     = r.sz;
    req_unsigned[g] = r.uns;
    req_addr[g]     = r.addr;
    req_wdata[g]    = r.wdata;
    req_valid[g]    = 1'b1;
    sb.push_back('{g, r.err, r.err ? 32'h0 : r.rdata});
    @(posedge clk);
    #1 req_valid[g] = 1'b0;
    resp_n = 0; wr_n = 0; rd_n = 0; strobes = 0;
    rdy_busy = 1'b0; rdy_after = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (mem_wr_en[g]) begin strobes++; wr_n = n; end
      if (mem_rd_en[g]) begin strobes++; rd_n = n; end
      if (n == 1 && !r.err) begin
        chk("mem_addr", mem_addr[g], r.addr & 32'hFFFF_FFFC);
        chk("mem_byte_en", 32'(mem_byte_en[g]), 32'(r.be));
        if (r.wr) chk("mem_wdata", mem_wdata[g], r.wd);
      end
      if (resp_valid[g] && resp_n == 0) resp_n = n;
      if ((resp_n == 0 || resp_n == n) && req_ready[g]) rdy_busy = 1'b1;
      if (resp_n != 0 && n == resp_n + 1) rdy_after = req_ready[g];
    end
    exp_n = r.err ? 1 : (r.wr ? 2 : 2 + lat(g));
    chk("resp_cycle", 32'(resp_n), 32'(exp_n));
    chk("strobe_count", 32'(strobes), r.err ? 32'd0 : 32'd1);
    if (!r.err)
      chk(r.wr ? "wr_cycle" : "rd_cycle", 32'(r.wr ? wr_n : rd_n), 32'd1);
    chk("ready_busy", 32'(rdy_busy), 32'd0);
    chk("ready_after", 32'(rdy_after), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic flag;
    rst = 1'b1;
    req_valid = '0; req_write = '0; req_unsigned = '0;
    req_size = '0; req_addr = '0; req_wdata = '0;

    //      wr  sz  uns addr          wdata         err rdata         be     wd
    t0.push_back('{1, 2'd2, 0, 32'h100, 32'hDEADBEEF, 0, 32'h0,       4'hF, 32'hDEADBEEF});
    t0.push_back('{0, 2'd2, 0, 32'h100, 32'h0,        0, 32'hDEADBEEF, 4'hF, 32'h0});
    t0.push_back('{1, 2'd0, 0, 32'h103, 32'h123456AB, 0, 32'h0,       4'h8, 32'hABABABAB});
    t0.push_back('{0, 2'd2, 0, 32'h100, 32'h0,        0, 32'hABADBEEF, 4'hF, 32'h0});
    t0.push_back('{1, 2'd0, 0, 32'h100, 32'h00000011, 0, 32'h0,       4'h1, 32'h11111111});
    t0.push_back('{0, 2'd0, 1, 32'h100, 32'h0,        0, 32'h00000011, 4'hF, 32'h0});
    t0.push_back('{0, 2'd0, 0, 32'h103, 32'h0,        0, 32'hFFFFFFAB, 4'hF, 32'h0});
    t0.push_back('{1, 2'd2, 0, 32'h200, 32'h00800000, 0, 32'h0,       4'hF, 32'h00800000});
    t0.push_back('{0, 2'd0, 0, 32'h202, 32'h0,        0, 32'hFFFFFF80, 4'hF, 32'h0});
    t0.push_back('{0, 2'd0, 1, 32'h202, 32'h0,        0, 32'h00000080, 4'hF, 32'h0});
    t0.push_back('{1, 2'd0, 0, 32'h201, 32'h0000007F, 0, 32'h0,       4'h2, 32'h7F7F7F7F});
    t0.push_back('{0, 2'd2, 0, 32'h200, 32'h0,        0, 32'h00807F00, 4'hF, 32'h0});
    t0.push_back('{0, 2'd0, 0, 32'h201, 32'h0,        0, 32'h0000007F, 4'hF, 32'h0});
    t0.push_back('{1, 2'd2, 0, 32'h300, 32'h80010000, 0, 32'h0,       4'hF, 32'h80010000});
    t0.push_back('{0, 2'd1, 0, 32'h302, 32'h0,        0, 32'hFFFF8001, 4'hF, 32'h0});
    t0.push_back('{0, 2'd1, 1, 32'h302, 32'h0,        0, 32'h00008001, 4'hF, 32'h0});
    t0.push_back('{0, 2'd1, 0, 32'h300, 32'h0,        0, 32'h00000000, 4'hF, 32'h0});
    t0.push_back('{1, 2'd1, 0, 32'h306, 32'h1234CAFE, 0, 32'h0,       4'hC, 32'hCAFECAFE});
    t0.push_back('{0, 2'd1, 0, 32'h306, 32'h0,        0, 32'hFFFFCAFE, 4'hF, 32'h0});
    t0.push_back('{0, 2'd1, 1, 32'h306, 32'h0,        0, 32'h0000CAFE, 4'hF, 32'h0});
    t0.push_back('{1, 2'd1, 0, 32'h300, 32'h00007001, 0, 32'h0,       4'h3, 32'h70017001});
    t0.push_back('{0, 2'd2, 0, 32'h300, 32'h0,        0, 32'h80017001, 4'hF, 32'h0});
    t0.push_back('{0, 2'd1, 0, 32'h101, 32'h0,        1, 32'h0,       4'h0, 32'h0});
    t0.push_back('{1, 2'd2, 0, 32'h102, 32'h11111111, 1, 32'h0,       4'h0, 32'h0});
    t0.push_back('{0, 2'd3, 0, 32'h100, 32'h0,        1, 32'h0,       4'h0, 32'h0});
    t0.push_back('{1, 2'd3, 0, 32'h100, 32'h22222222, 1, 32'h0,       4'h0, 32'h0});
    t0.push_back('{0, 2'd2, 0, 32'h302, 32'h0,        1, 32'h0,       4'h0, 32'h0});
    t0.push_back('{1, 2'd1, 0, 32'h301, 32'h33333333, 1, 32'h0,       4'h0, 32'h0});
    t0.push_back('{0, 2'd2, 0, 32'h100, 32'h0,        0, 32'hABADBE11, 4'hF, 32'h0});
    t0.push_back('{0, 2'd2, 0, 32'h300, 32'h0,        0, 32'h80017001, 4'hF, 32'h0});

    t1.push_back('{1, 2'd2, 0, 32'h100, 32'h13579BDF, 0, 32'h0,       4'hF, 32'h13579BDF});
    t1.push_back('{0, 2'd2, 0, 32'h100, 32'h0,        0, 32'h13579BDF, 4'hF, 32'h0});
    t1.push_back('{0, 2'd0, 0, 32'h101, 32'h0,        0, 32'hFFFFFF9B, 4'hF, 32'h0});
    t1.push_back('{0, 2'd1, 1, 32'h102, 32'h0,        0, 32'h00001357, 4'hF, 32'h0});

    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_req_ready", 32'(req_ready[i]), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid[i]), 32'd0);
      chk("rst_resp_error", 32'(resp_error[i]), 32'd0);
      chk("rst_resp_rdata", resp_rdata[i], 32'd0);
      chk("rst_mem_addr", mem_addr[i], 32'd0);
      chk("rst_mem_rd_en", 32'(mem_rd_en[i]), 32'd0);
      chk("rst_mem_wr_en", 32'(mem_wr_en[i]), 32'd0);
      chk("rst_mem_byte_en", 32'(mem_byte_en[i]), 32'd0);
      chk("rst_mem_wdata", mem_wdata[i], 32'd0);
    end
    rst = 1'b0;

    foreach (t0[k]) run(0, t0[k]);
    foreach (t1[k]) run(1, t1[k]);

    // Reset while a latency-3 load sits in WAIT.
    @(negedge clk);
    req_write[1] = 1'b0; req_size[1] = 2'd2; req_unsigned[1] = 1'b0;
    req_addr[1] = 32'h100; req_valid[1] = 1'b1;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(negedge clk);
    chk("rstw_rd_en", 32'(mem_rd_en[1]), 32'd1);
    @(negedge clk);
    chk("rstw_busy", 32'(req_ready[1]), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rstw_ready", 32'(req_ready[1]), 32'd1);
    chk("rstw_resp_valid", 32'(resp_valid[1]), 32'd0);
    chk("rstw_rd_en_low", 32'(mem_rd_en[1]), 32'd0);
    flag = 1'b0;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (resp_valid[1]) flag = 1'b1;
    end
    chk("rstw_no_resp", 32'(flag), 32'd0);
    run(1, '{0, 2'd2, 0, 32'h100, 32'h0, 0, 32'h13579BDF, 4'hF, 32'h0});
    run(1, '{0, 2'd0, 1, 32'h103, 32'h0, 0, 32'h00000013, 4'hF, 32'h0});

    repeat (3) @(negedge clk);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
